// File: rtl/pred_scan_ctrl_if.sv
// rtl/pred_scan_ctrl_if.sv - sample handshake and issued-sample bus of pred_scan_ctrl
// Signals:
//   s_valid / s_ready     source sample handshake (accept = s_valid & s_ready)
//   en                    registered enable, one cycle per accepted sample
//   spec_fst              issued sample is band 0
//   en_block_cnt          issued sample closes a block (or the frame)
//   en_fst_blo            issued sample lies in the first block of the frame
//   last                  issued sample is the final sample of the frame
//   x / y / z             coordinates of the issued sample
// Modports: master = sample source / consumer side, slave = controller side.
interface pred_scan_ctrl_if #(
  parameter int CW = 16
);
  logic          s_valid;
  logic          s_ready;
  logic          en;
  logic          spec_fst;
  logic          en_block_cnt;
  logic          en_fst_blo;
  logic          last;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [CW-1:0] z;

  modport master (
    output s_valid,
    input  s_ready, en, spec_fst, en_block_cnt, en_fst_blo, last, x, y, z
  );

  modport slave (
    input  s_valid,
    output s_ready, en, spec_fst, en_block_cnt, en_fst_blo, last, x, y, z
  );
endinterface

// File: rtl/pred_scan_ctrl.sv
// rtl/pred_scan_ctrl.sv - BIP-order frame sequencer for the predictor front end
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start_i         frame start request, only looked at in IDLE
//   hold_i          downstream stall, blocks s_ready
//   s_if (slave)    sample handshake plus registered enable, flags, coordinates
//   busy_o          controller is not IDLE
//   done_o          one-cycle frame completion pulse
//   stall_cnt_o     (only with PRED_SCAN_STALL_CNT_EN) cycles in RUN with
//                   s_valid=1 and hold_i=1, saturating
// Scan order is z fastest, then x, then y. Flags and coordinates issued with
// en describe the accepted sample, i.e. they decode the counters before they
// advance.
module pred_scan_ctrl #(
  parameter int NX         = 16,
  parameter int NY         = 16,
  parameter int NZ         = 8,
  parameter int CW         = 16,
  parameter int BLOCK_SIZE = 64,
  parameter int PIPE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            hold_i,
  pred_scan_ctrl_if.slave s_if,
  output logic            busy_o,
  output logic            done_o
`ifdef PRED_SCAN_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt_o
`endif
);

  localparam int BW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int DW = (PIPE_DEPTH > 0) ? $clog2(PIPE_DEPTH + 1) : 1;

  localparam logic [CW-1:0] X_MAX = CW'(NX - 1);
  localparam logic [CW-1:0] Y_MAX = CW'(NY - 1);
  localparam logic [CW-1:0] Z_MAX = CW'(NZ - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BLOCK_SIZE - 1);
  localparam logic [DW-1:0] D_MAX = DW'(PIPE_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [CW-1:0] xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          fst_blo_q, fst_blo_d;
  logic          en_q, en_d;
  logic          spec_fst_q, spec_fst_d;
  logic          ebc_q, ebc_d;
  logic          fb_q, fb_d;
  logic          last_q, last_d;

  logic ready_w;
  logic accept_w;
  logic final_w;

  assign ready_w  = (state_q == RUN) & ~hold_i;
  assign accept_w = s_if.s_valid & ready_w;
  assign final_w  = (x_q == X_MAX) & (y_q == Y_MAX) & (z_q == Z_MAX);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    xo_d       = xo_q;
    yo_d       = yo_q;
    zo_d       = zo_q;
    blk_d      = blk_q;
    fst_blo_d  = fst_blo_q;
    drain_d    = drain_q;
    en_d       = 1'b0;
    spec_fst_d = 1'b0;
    ebc_d      = 1'b0;
    fb_d       = 1'b0;
    last_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d       = '0;
          y_d       = '0;
          z_d       = '0;
          blk_d     = '0;
          fst_blo_d = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (accept_w) begin
          en_d       = 1'b1;
          spec_fst_d = (z_q == '0);
          ebc_d      = (blk_q == B_MAX) | final_w;
          fb_d       = fst_blo_q;
          last_d     = final_w;
          xo_d       = x_q;
          yo_d       = y_q;
          zo_d       = z_q;
          // z -> x -> y carry chain; y saturates on the last line
          if (z_q == Z_MAX) begin
            z_d = '0;
            if (x_q == X_MAX) begin
              x_d = '0;
              if (y_q != Y_MAX) begin
                y_d = y_q + CW'(1);
              end
            end else begin
              x_d = x_q + CW'(1);
            end
          end else begin
            z_d = z_q + CW'(1);
          end
          if (blk_q == B_MAX) begin
            blk_d     = '0;
            fst_blo_d = 1'b0;
          end else begin
            blk_d = blk_q + BW'(1);
          end
          if (final_w) begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // counts 0..PIPE_DEPTH so done lands PIPE_DEPTH+1 cycles after the last en
        if (drain_q == D_MAX) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      xo_q       <= '0;
      yo_q       <= '0;
      zo_q       <= '0;
      blk_q      <= '0;
      fst_blo_q  <= 1'b0;
      drain_q    <= '0;
      en_q       <= 1'b0;
      spec_fst_q <= 1'b0;
      ebc_q      <= 1'b0;
      fb_q       <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      xo_q       <= xo_d;
      yo_q       <= yo_d;
      zo_q       <= zo_d;
      blk_q      <= blk_d;
      fst_blo_q  <= fst_blo_d;
      drain_q    <= drain_d;
      en_q       <= en_d;
      spec_fst_q <= spec_fst_d;
      ebc_q      <= ebc_d;
      fb_q       <= fb_d;
      last_q     <= last_d;
    end
  end

`ifdef PRED_SCAN_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start_i) begin
      stall_d = '0;
    end else if (state_q == RUN && s_if.s_valid && hold_i && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

  assign s_if.s_ready      = ready_w;
  assign s_if.en           = en_q;
  assign s_if.spec_fst     = spec_fst_q;
  assign s_if.en_block_cnt = ebc_q;
  assign s_if.en_fst_blo   = fb_q;
  assign s_if.last         = last_q;
  assign s_if.x            = xo_q;
  assign s_if.y            = yo_q;
  assign s_if.z            = zo_q;
  assign busy_o            = (state_q != IDLE);
  assign done_o            = (state_q == DONE);

endmodule

// File: tb/tb_pred_scan_ctrl.sv
// tb/tb_pred_scan_ctrl.sv - self-checking bench for pred_scan_ctrl (BLOCK_SIZE 4 and 5 in lockstep)
module tb_pred_scan_ctrl;
  localparam int NX = 2, NY = 2, NZ = 3, CW = 4, PD = 4;
  localparam int N  = NX * NY * NZ;

  logic clk, rst, start, hold, valid;
  logic busy4, done4, busy5, done5;
`ifdef PRED_SCAN_STALL_CNT_EN
  logic [31:0] stall4, stall5;
`endif

  pred_scan_ctrl_if #(.CW(CW)) bus4 ();
  pred_scan_ctrl_if #(.CW(CW)) bus5 ();
  assign bus4.s_valid = valid;
  assign bus5.s_valid = valid;

  pred_scan_ctrl #(.NX(NX), .NY(NY), .NZ(NZ), .CW(CW), .BLOCK_SIZE(4), .PIPE_DEPTH(PD)) dut4 (
    .clk(clk), .rst(rst), .start_i(start), .hold_i(hold), .s_if(bus4.slave),
    .busy_o(busy4), .done_o(done4)
`ifdef PRED_SCAN_STALL_CNT_EN
    , .stall_cnt_o(stall4)
`endif
  );

  pred_scan_ctrl #(.NX(NX), .NY(NY), .NZ(NZ), .CW(CW), .BLOCK_SIZE(5), .PIPE_DEPTH(PD)) dut5 (
    .clk(clk), .rst(rst), .start_i(start), .hold_i(hold), .s_if(bus5.slave),
    .busy_o(busy5), .done_o(done5)
`ifdef PRED_SCAN_STALL_CNT_EN
    , .stall_cnt_o(stall5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done; k = samples accepted
  int ph = 0, k = 0, fin = 0, mcyc = 0, stall_m = 0;
  int m_x = 0, m_y = 0, m_z = 0;
  bit m_en, m_sf, m_last, m_ebc4, m_ebc5, m_fb4, m_fb5;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ph = 0; k = 0; stall_m = 0;
        m_x = 0; m_y = 0; m_z = 0;
        m_en = 0; m_sf = 0; m_last = 0; m_ebc4 = 0; m_ebc5 = 0; m_fb4 = 0; m_fb5 = 0;
      end else begin
        bit acc;
        acc = (ph == 1) && valid && !hold;
        m_en = acc; m_sf = 0; m_last = 0; m_ebc4 = 0; m_ebc5 = 0; m_fb4 = 0; m_fb5 = 0;
        if (acc) begin
          m_z    = k % NZ;
          m_x    = (k / NZ) % NX;
          m_y    = k / (NZ * NX);
          m_sf   = (k % NZ) == 0;
          m_last = (k == N - 1);
          m_ebc4 = ((k % 4) == 3) || m_last;
          m_ebc5 = ((k % 5) == 4) || m_last;
          m_fb4  = k < 4;
          m_fb5  = k < 5;
        end
        mcyc++;
        case (ph)
          0: if (start) begin ph = 1; k = 0; stall_m = 0; end
          1: begin
            if (valid && hold) stall_m++;
            if (acc) begin
              k++;
              if (k == N) begin ph = 2; fin = mcyc; end
            end
          end
          2: if (mcyc == fin + PD + 1) ph = 3;
          default: ph = 0;
        endcase
      end
    end
  end

  // Per-frame record of issued pulses (bit i = pulse i+1)
  int cur_mode = 0, clr_req = 0, clr_ack = 0;
  int tcyc = 0, pulse_n = 0, last_en = -10, done_gap = -1;
  bit prev_done = 0, busy_after = 1;
  logic [15:0] sf_b, fb4_b, ebc4_b, fb5_b, ebc5_b, last_b;
  int px[16], py[16], pz[16];

  task automatic compare_all();
    check("en4", bus4.en, m_en);
    check("en5", bus5.en, m_en);
    check("ready4", bus4.s_ready, 32'((ph == 1) && !hold));
    check("ready5", bus5.s_ready, 32'((ph == 1) && !hold));
    check("spec_fst4", bus4.spec_fst, m_sf);
    check("spec_fst5", bus5.spec_fst, m_sf);
    check("last4", bus4.last, m_last);
    check("last5", bus5.last, m_last);
    check("ebc4", bus4.en_block_cnt, m_ebc4);
    check("ebc5", bus5.en_block_cnt, m_ebc5);
    check("fst_blo4", bus4.en_fst_blo, m_fb4);
    check("fst_blo5", bus5.en_fst_blo, m_fb5);
    check("x4", bus4.x, m_x);
    check("y4", bus4.y, m_y);
    check("z4", bus4.z, m_z);
    check("x5", bus5.x, m_x);
    check("y5", bus5.y, m_y);
    check("z5", bus5.z, m_z);
    check("busy4", busy4, 32'(ph != 0));
    check("busy5", busy5, 32'(ph != 0));
    check("done4", done4, 32'(ph == 3));
    check("done5", done5, 32'(ph == 3));
`ifdef PRED_SCAN_STALL_CNT_EN
    check("stall4", stall4, stall_m);
    check("stall5", stall5, stall_m);
`endif
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tcyc++;
      if (clr_req != clr_ack) begin
        pulse_n = 0; last_en = -10; done_gap = -1; busy_after = 1; prev_done = 0;
        sf_b = '0; fb4_b = '0; ebc4_b = '0; fb5_b = '0; ebc5_b = '0; last_b = '0;
        clr_ack = clr_req;
      end
      compare_all();
      if (prev_done) busy_after = busy4;
      prev_done = done4;
      if (done4) done_gap = tcyc - last_en;
      if (bus4.en) begin
        if (cur_mode == 2 && pulse_n > 0) check("sparse_gap", 32'((tcyc - last_en) >= 2), 1);
        if (pulse_n < 16) begin
          sf_b[pulse_n]   = bus4.spec_fst;
          fb4_b[pulse_n]  = bus4.en_fst_blo;
          ebc4_b[pulse_n] = bus4.en_block_cnt;
          fb5_b[pulse_n]  = bus5.en_fst_blo;
          ebc5_b[pulse_n] = bus5.en_block_cnt;
          last_b[pulse_n] = bus4.last;
          px[pulse_n] = int'(bus4.x);
          py[pulse_n] = int'(bus4.y);
          pz[pulse_n] = int'(bus4.z);
        end
        pulse_n++;
        last_en = tcyc;
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_en4"}, bus4.en, 0);
    check({tag, "_en5"}, bus5.en, 0);
    check({tag, "_flags4"}, {bus4.spec_fst, bus4.en_block_cnt, bus4.en_fst_blo, bus4.last}, 0);
    check({tag, "_flags5"}, {bus5.spec_fst, bus5.en_block_cnt, bus5.en_fst_blo, bus5.last}, 0);
    check({tag, "_xyz4"}, {bus4.x, bus4.y, bus4.z}, 0);
    check({tag, "_xyz5"}, {bus5.x, bus5.y, bus5.z}, 0);
    check({tag, "_busy_done"}, {busy4, done4, busy5, done5}, 0);
    check({tag, "_ready"}, {bus4.s_ready, bus5.s_ready}, 0);
  endtask

  // mode: 0 continuous, 1 hold after 2nd accept, 2 toggling valid, 3 random, 4 start pulse in RUN
  task automatic run_frame(input int mode);
    int budget, hold_left;
    bit hold_done, start_done;
    budget = 0; hold_left = 0; hold_done = 0; start_done = 0;
    cur_mode = mode;
    @(negedge clk);
    clr_req++;
    start = 1'b1; hold = 1'b0;
    valid = (mode == 2) ? 1'b0 : 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (ph != 0 && budget < 400) begin
      case (mode)
        1: begin
          valid = 1'b1;
          if (!hold_done && k == 2) begin hold_done = 1; hold_left = 3; end
          hold = (hold_left > 0);
          if (hold_left > 0) hold_left--;
        end
        2: valid = ~valid;
        3: begin
          valid = 1'($urandom_range(0, 1));
          hold  = ($urandom_range(0, 3) == 0);
          start = ($urandom_range(0, 7) == 0);
        end
        4: begin
          valid = 1'b1;
          start = (!start_done && k == 3);
          if (start) start_done = 1;
        end
        default: valid = 1'b1;
      endcase
      @(negedge clk);
      budget++;
    end
    start = 1'b0; valid = 1'b0; hold = 1'b0;
    check("frame_completed", 32'(ph == 0), 1);
    check("pulse_count", pulse_n, N);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; valid = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic frame, both block sizes
    run_frame(0);
    check("basic_spec_fst", sf_b[11:0], 12'h249);
    check("basic_fst_blo4", fb4_b[11:0], 12'h00F);
    check("basic_ebc4", ebc4_b[11:0], 12'h888);
    check("basic_last", last_b[11:0], 12'h800);
    check("partial_fst_blo5", fb5_b[11:0], 12'h01F);
    check("partial_ebc5", ebc5_b[11:0], 12'hA10);
    check("done_gap", done_gap, 5);
    check("busy_after_done", busy_after, 0);

    // backpressure
    run_frame(1);
    check("bp_x3", px[2], 0);
    check("bp_y3", py[2], 0);
    check("bp_z3", pz[2], 2);
`ifdef PRED_SCAN_STALL_CNT_EN
    check("bp_stall4", stall4, 3);
    check("bp_stall5", stall5, 3);
`endif

    // sparse source
    run_frame(2);
    check("sparse_spec_fst", sf_b[11:0], 12'h249);
    check("sparse_ebc5", ebc5_b[11:0], 12'hA10);

    // random valid/hold with stray start requests
    for (int i = 0; i < 3; i++) run_frame(3);

    // reset mid-frame after 6 accepts
    @(negedge clk);
    start = 1'b1; valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && k < 6; i++) @(negedge clk);
    check("midrst_k", k, 6);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    #3 rst = 1'b0;
    valid = 1'b0;
    repeat (2) @(negedge clk);

    // restart with an ignored start pulse in RUN
    run_frame(4);
    check("restart_xyz0", {px[0][3:0], py[0][3:0], pz[0][3:0]}, 0);
    check("restart_fst_blo", fb4_b[0], 1);
    check("restart_ebc4", ebc4_b[11:0], 12'h888);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
